// File: rtl/tinker_mem_pkg.sv
// Shared types and defaults for the tinker memory arbiter.
//   arb_state_t : arbiter FSM states
//   port_id_t   : which requester owns the in-flight access
package tinker_mem_pkg;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } port_id_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive data grants taken while fetch waits.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   inc          : data grant while fetch pending
//   clr          : fetch granted, or fetch not requesting at arbitration
//   cnt          : current count
//   at_limit     : count has reached LIMIT; fetch must win next
module arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    assign at_limit = (cnt == LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares the single-ported memory between instruction fetch and load/store.
// A winning request is latched straight into the memory-port registers, the
// access happens the following cycle, and the response pulses the cycle after.
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   if_req/if_addr               : fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata    : fetch grant, response pulse, instruction
//   d_req/d_we/d_addr/d_wdata    : load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata       : data grant, response pulse, load data
//   mem_*                        : memory port, all zero outside the access
//   busy                         : access or response in progress
module tinker_mem_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int INSTR_W      = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [INSTR_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t state;
    port_id_t   owner;
    logic       arb_en;
    logic       at_limit;
    logic       pick_if;
    logic       pick_d;
    logic [3:0] starve_cnt;

    // Grants are combinational; gating with reset_n keeps every output low
    // while reset is held, even if a requester is already asserting.
    assign arb_en  = reset_n && (state != ARB_ACCESS);
    assign pick_if = arb_en && if_req && (!d_req || at_limit);
    assign pick_d  = arb_en && d_req && !pick_if;
    assign if_gnt  = pick_if;
    assign d_gnt   = pick_d;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (4)
    ) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (pick_d && if_req),
        .clr      (arb_en && (!if_req || pick_if)),
        .cnt      (starve_cnt),
        .at_limit (at_limit)
    );

    // The mem_* registers double as the latched request: they are loaded at
    // the grant edge and cleared at the end of the access, so an async reset
    // during the access drops mem_write_en before the store can commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ARB_IDLE;
            owner        <= PORT_IF;
            busy         <= 1'b0;
            if_rvalid    <= 1'b0;
            d_rvalid     <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            mem_addr     <= '0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            mem_wdata    <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                ARB_IDLE, ARB_RESP: begin
                    if (pick_if || pick_d) begin
                        state        <= ARB_ACCESS;
                        busy         <= 1'b1;
                        owner        <= pick_if ? PORT_IF : PORT_D;
                        mem_addr     <= pick_if ? if_addr : d_addr;
                        mem_read_en  <= pick_if || !d_we;
                        mem_write_en <= pick_d && d_we;
                        mem_wdata    <= (pick_d && d_we) ? d_wdata : '0;
                    end else begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ARB_ACCESS: begin
                    state        <= ARB_RESP;
                    busy         <= 1'b1;
                    mem_addr     <= '0;
                    mem_read_en  <= 1'b0;
                    mem_write_en <= 1'b0;
                    mem_wdata    <= '0;
                    if (owner == PORT_IF) begin
                        if_rdata  <= mem_rdata[INSTR_W-1:0];
                        if_rvalid <= 1'b1;
                    end else begin
                        // A store acknowledge returns zero data.
                        d_rdata  <= mem_write_en ? '0 : mem_rdata;
                        d_rvalid <= 1'b1;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
module tb_tinker_mem_arbiter;
    import tinker_mem_pkg::*;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int IW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [IW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_read_en, mem_write_en;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    tinker_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .INSTR_W(IW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [63:0] init_val(int i);
        return {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'h5A5A_0000};
    endfunction

    // Memory environment: 256 words, word index = addr[10:3].
    logic [63:0] mem [0:255];
    bit          mem_init = 1'b0;
    assign mem_rdata = mem[mem_addr[10:3]];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_addr[10:3]] <= mem_wdata;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a grant becomes an access next cycle and a
    // response the cycle after; arbitration is allowed whenever nothing is in
    // its access cycle.
    typedef struct {
        bit          vld;
        bit          is_if;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] res;
    } txn_t;

    txn_t        m_acc, m_resp, nxt;
    int          s = 0;
    logic [63:0] ref_mem [0:255];
    bit          ref_init = 1'b0;
    logic [63:0] exp_if_rd = '0;
    logic [63:0] exp_d_rd = '0;
    int          we_cnt = 0, acc_cnt = 0, dg_cnt = 0;
    bit          arb, w_if, w_d;

    initial begin
        m_acc  = '{default: '0};
        m_resp = '{default: '0};
    end

    always @(negedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        if (mem_write_en) we_cnt++;
        if (mem_read_en || mem_write_en) acc_cnt++;
        if (d_gnt) dg_cnt++;
        if (!reset_n) begin
            m_acc.vld  = 1'b0;
            m_resp.vld = 1'b0;
            s          = 0;
            exp_if_rd  = '0;
            exp_d_rd   = '0;
            check("rst_if_gnt",   64'(if_gnt), 64'(0));
            check("rst_d_gnt",    64'(d_gnt), 64'(0));
            check("rst_if_rvld",  64'(if_rvalid), 64'(0));
            check("rst_d_rvld",   64'(d_rvalid), 64'(0));
            check("rst_if_rdata", 64'(if_rdata), 64'(0));
            check("rst_d_rdata",  d_rdata, 64'(0));
            check("rst_mem_addr", mem_addr, 64'(0));
            check("rst_mem_rd",   64'(mem_read_en), 64'(0));
            check("rst_mem_wr",   64'(mem_write_en), 64'(0));
            check("rst_mem_wd",   mem_wdata, 64'(0));
            check("rst_busy",     64'(busy), 64'(0));
        end else begin
            arb  = !m_acc.vld;
            w_if = arb && if_req && (!d_req || s == LIMIT);
            w_d  = arb && d_req && !w_if;
            check("if_gnt", 64'(if_gnt), 64'(w_if));
            check("d_gnt",  64'(d_gnt), 64'(w_d));
            check("mem_addr", mem_addr, m_acc.vld ? m_acc.addr : 64'(0));
            check("mem_rd", 64'(mem_read_en), 64'(m_acc.vld && !m_acc.we));
            check("mem_wr", 64'(mem_write_en), 64'(m_acc.vld && m_acc.we));
            check("mem_wd", mem_wdata, (m_acc.vld && m_acc.we) ? m_acc.wdata : 64'(0));
            if (m_resp.vld) begin
                if (m_resp.is_if) exp_if_rd = m_resp.res;
                else              exp_d_rd  = m_resp.res;
            end
            check("if_rvalid", 64'(if_rvalid), 64'(m_resp.vld && m_resp.is_if));
            check("d_rvalid",  64'(d_rvalid), 64'(m_resp.vld && !m_resp.is_if));
            check("if_rdata",  64'(if_rdata), exp_if_rd);
            check("d_rdata",   d_rdata, exp_d_rd);
            check("busy", 64'(busy), 64'(m_acc.vld || m_resp.vld));
            nxt = m_acc;
            if (nxt.vld) begin
                if (nxt.we) begin
                    ref_mem[nxt.addr[10:3]] = nxt.wdata;
                    nxt.res = '0;
                end else begin
                    nxt.res = ref_mem[nxt.addr[10:3]];
                    if (nxt.is_if) nxt.res = {32'b0, nxt.res[31:0]};
                end
            end
            m_resp       = nxt;
            m_acc.vld    = w_if || w_d;
            m_acc.is_if  = w_if;
            m_acc.we     = w_d && d_we;
            m_acc.addr   = w_if ? if_addr : d_addr;
            m_acc.wdata  = d_wdata;
            m_acc.res    = '0;
            if (arb) begin
                if (!if_req || w_if) s = 0;
                else if (w_d && s < LIMIT) s++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int  nd, we0, a0, d0;
        bit  got, gi, gd;

        repeat (3) @(posedge clk);
        #2;
        check("rst_state", 64'(dut.state), 64'(ARB_IDLE));
        check("rst_starve", 64'(dut.u_starve.cnt), 64'(0));
        reset_n = 1'b1;
        step();

        // Single fetch (word written through the data port first).
        d_req = 1; d_we = 1; d_addr = 64'h2000; d_wdata = 64'h8A000004;
        @(negedge clk); check("sf_store_gnt", 64'(d_gnt), 64'(1));
        step(); d_req = 0;
        idle(3);
        if_req = 1; if_addr = 64'h2000;
        @(negedge clk); check("sf_if_gnt", 64'(if_gnt), 64'(1));
        step(); if_req = 0;
        @(negedge clk);
        check("sf_rd_en", 64'(mem_read_en), 64'(1));
        check("sf_addr", mem_addr, 64'h2000);
        @(negedge clk);
        check("sf_rvalid", 64'(if_rvalid), 64'(1));
        check("sf_rdata", 64'(if_rdata), 64'h8A000004);
        idle(3);

        // Store then load.
        we0 = we_cnt;
        d_req = 1; d_we = 1; d_addr = 64'h100; d_wdata = 64'hDEADBEEF_01234567;
        @(negedge clk); check("sl_st_gnt", 64'(d_gnt), 64'(1));
        step(); d_req = 0;
        @(negedge clk); check("sl_wr_en", 64'(mem_write_en), 64'(1));
        @(negedge clk);
        check("sl_ack", 64'(d_rvalid), 64'(1));
        check("sl_ack_data", d_rdata, 64'(0));
        step();
        d_req = 1; d_we = 0;
        @(negedge clk); check("sl_ld_gnt", 64'(d_gnt), 64'(1));
        step(); d_req = 0;
        @(negedge clk);
        @(negedge clk);
        check("sl_ld_rvalid", 64'(d_rvalid), 64'(1));
        check("sl_ld_data", d_rdata, 64'hDEADBEEF_01234567);
        idle(3);
        check("sl_wr_cycles", 64'(we_cnt - we0), 64'(1));

        // Simultaneous requests.
        if_req = 1; if_addr = 64'h2000;
        d_req = 1; d_we = 0; d_addr = 64'h100;
        @(negedge clk);
        check("sim_d_gnt0", 64'(d_gnt), 64'(1));
        check("sim_if_gnt0", 64'(if_gnt), 64'(0));
        step(); d_req = 0;
        @(negedge clk); check("sim_if_gnt1", 64'(if_gnt), 64'(0));
        @(negedge clk); check("sim_if_gnt2", 64'(if_gnt), 64'(1));
        step(); if_req = 0;
        @(negedge clk);
        @(negedge clk); check("sim_if_rvld4", 64'(if_rvalid), 64'(1));
        idle(3);

        // Starvation: both held continuously.
        if_req = 1; if_addr = 64'h2000;
        d_req = 1; d_we = 0; d_addr = 64'h100;
        nd = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (if_gnt) got = 1;
            else if (d_gnt) nd++;
        end
        check("starve_fetch_seen", 64'(got), 64'(1));
        check("starve_d_grants", 64'(nd), 64'(LIMIT));
        step(); if_req = 0; d_req = 0;
        check("starve_cnt_clr", 64'(dut.u_starve.cnt), 64'(0));
        idle(3);

        // Withdrawn data request pulsed during a fetch access.
        a0 = acc_cnt; d0 = dg_cnt;
        if_req = 1; if_addr = 64'h2000;
        @(negedge clk); check("wd_if_gnt", 64'(if_gnt), 64'(1));
        step(); if_req = 0; d_req = 1; d_we = 1; d_addr = 64'h300; d_wdata = 64'h55;
        step(); d_req = 0;
        idle(3);
        check("wd_no_dgnt", 64'(dg_cnt - d0), 64'(0));
        check("wd_one_access", 64'(acc_cnt - a0), 64'(1));

        // Reset in the access cycle of a store.
        d_req = 1; d_we = 1; d_addr = 64'h200; d_wdata = 64'hCAFEF00D_12345678;
        @(negedge clk); check("rs_gnt", 64'(d_gnt), 64'(1));
        step(); d_req = 0;
        check("rs_wr_before", 64'(mem_write_en), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("rs_wr_drop", 64'(mem_write_en), 64'(0));
        check("rs_busy", 64'(busy), 64'(0));
        check("rs_mem_addr", mem_addr, 64'(0));
        check("rs_d_rdata", d_rdata, 64'(0));
        check("rs_if_rdata", 64'(if_rdata), 64'(0));
        check("rs_state", 64'(dut.state), 64'(ARB_IDLE));
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        step(); step();
        check("rs_mem_kept", mem[10'h200 >> 3], init_val(10'h200 >> 3));

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            gi = if_gnt; gd = d_gnt;
            step();
            if (if_req && gi) begin
                if ($urandom_range(3) != 0) if_req = 0;
            end else if (if_req && $urandom_range(19) == 0) begin
                if_req = 0;
            end else if (!if_req && $urandom_range(2) == 0) begin
                if_req  = 1;
                if_addr = {$urandom, $urandom};
            end
            if (d_req && gd) begin
                if ($urandom_range(3) != 0) d_req = 0;
            end else if (d_req && $urandom_range(19) == 0) begin
                d_req = 0;
            end else if (!d_req && $urandom_range(1) == 0) begin
                d_req   = 1;
                d_we    = $urandom_range(1) == 1;
                d_addr  = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
            end
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
